// File: rtl/instr_buffer_reader_if.sv
// Handshake bundle between the buffer reader, the instruction buffer read port
// and the downstream decode/dispatch stage.
interface instr_buffer_reader_if #(
  parameter int Instr_word_size = 16,
  parameter int bs = 16
);
  localparam int IW = $clog2(bs);

  logic [IW-1:0]              rd_index;
  logic                       rd_en;
  logic [Instr_word_size-1:0] rd_data;
  logic                       out_valid;
  logic                       out_ready;
  logic [Instr_word_size-1:0] out_instr;
  logic [IW-1:0]              out_index;

  modport master (
    output rd_index, rd_en, out_valid, out_instr, out_index,
    input  rd_data, out_ready
  );

  modport slave (
    input  rd_index, rd_en, out_valid, out_instr, out_index,
    output rd_data, out_ready
  );
endinterface

// File: rtl/instr_buffer_reader.sv
// Read-side sequencer for the instruction buffer: walks a wrapping slot range,
// filters null words and hands the rest downstream through a 2-entry queue.
module instr_buffer_reader #(
  parameter int Instr_word_size = 16,
  parameter int bs = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [$clog2(bs)-1:0]   start_index,
  input  logic [$clog2(bs):0]     length,
  input  logic                    skip_null,
  input  logic                    flush,
  output logic                    busy,
  output logic                    done,
  instr_buffer_reader_if.master   bus
);
  localparam int IW = $clog2(bs);
  localparam int CW = IW + 1;
  localparam logic [CW-1:0] CNT_ZERO = CW'(1'b0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);
  localparam logic [IW-1:0] PTR_ZERO = IW'(1'b0);
  localparam logic [IW-1:0] PTR_ONE  = IW'(1'b1);
  localparam logic [Instr_word_size-1:0] WORD_ZERO = {Instr_word_size{1'b0}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                     state_r;
  logic [IW-1:0]              ptr_r;
  logic [CW-1:0]              remain_r;
  logic                       busy_r;
  logic                       done_r;
  logic                       inflight_r;
  logic [IW-1:0]              inflight_idx_r;
  logic [1:0]                 q_cnt_r;
  logic [Instr_word_size-1:0] q0_word_r;
  logic [Instr_word_size-1:0] q1_word_r;
  logic [IW-1:0]              q0_idx_r;
  logic [IW-1:0]              q1_idx_r;

  logic       pop_s;
  logic       push_s;
  logic [1:0] occ_after_s;
  logic       issue_s;
  logic       drain_ok_s;

  // Credit counts the head being popped this cycle so a free-flowing
  // downstream sustains one read per cycle; this makes rd_en combinational.
  always_comb begin
    pop_s       = (q_cnt_r != 2'd0) && bus.out_ready;
    push_s      = inflight_r && !(skip_null && (bus.rd_data == WORD_ZERO));
    occ_after_s = q_cnt_r - {1'b0, pop_s} + {1'b0, inflight_r};
    issue_s     = (state_r == ISSUE) && (remain_r != CNT_ZERO) && (occ_after_s < 2'd2);
    drain_ok_s  = !inflight_r && ((q_cnt_r == 2'd0) || ((q_cnt_r == 2'd1) && pop_s));
  end

  assign bus.rd_index  = ptr_r;
  assign bus.rd_en     = issue_s;
  assign bus.out_valid = (q_cnt_r != 2'd0);
  assign bus.out_instr = q0_word_r;
  assign bus.out_index = q0_idx_r;
  assign busy          = busy_r;
  assign done          = done_r;

  // Sequencer FSM: pointer, remaining count, busy and done pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r  <= IDLE;
      ptr_r    <= PTR_ZERO;
      remain_r <= CNT_ZERO;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else if (flush) begin
      state_r  <= IDLE;
      remain_r <= CNT_ZERO;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            ptr_r    <= start_index;
            remain_r <= length;
            busy_r   <= 1'b1;
            if (length == CNT_ZERO) begin
              state_r <= DONE;
              done_r  <= 1'b1;
            end else begin
              state_r <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (issue_s) begin
            ptr_r    <= ptr_r + PTR_ONE;
            remain_r <= remain_r - CNT_ONE;
            if (remain_r == CNT_ONE) begin
              state_r <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (drain_ok_s) begin
            state_r <= DONE;
            done_r  <= 1'b1;
          end
        end
        DONE: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  // Return path: in-flight tracking and the 2-entry shift queue (head in q0).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inflight_r     <= 1'b0;
      inflight_idx_r <= PTR_ZERO;
      q_cnt_r        <= 2'd0;
      q0_word_r      <= WORD_ZERO;
      q1_word_r      <= WORD_ZERO;
      q0_idx_r       <= PTR_ZERO;
      q1_idx_r       <= PTR_ZERO;
    end else if (flush) begin
      inflight_r <= 1'b0;
      q_cnt_r    <= 2'd0;
    end else begin
      inflight_r <= issue_s;
      if (issue_s) begin
        inflight_idx_r <= ptr_r;
      end
      case ({push_s, pop_s})
        2'b10: begin
          if (q_cnt_r == 2'd0) begin
            q0_word_r <= bus.rd_data;
            q0_idx_r  <= inflight_idx_r;
          end else begin
            q1_word_r <= bus.rd_data;
            q1_idx_r  <= inflight_idx_r;
          end
          q_cnt_r <= q_cnt_r + 2'd1;
        end
        2'b01: begin
          q0_word_r <= q1_word_r;
          q0_idx_r  <= q1_idx_r;
          q_cnt_r   <= q_cnt_r - 2'd1;
        end
        2'b11: begin
          if (q_cnt_r == 2'd1) begin
            q0_word_r <= bus.rd_data;
            q0_idx_r  <= inflight_idx_r;
          end else begin
            q0_word_r <= q1_word_r;
            q0_idx_r  <= q1_idx_r;
            q1_word_r <= bus.rd_data;
            q1_idx_r  <= inflight_idx_r;
          end
        end
        default: begin
          q_cnt_r <= q_cnt_r;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_instr_buffer_reader.sv
// Randomised bench for instr_buffer_reader: a registered-read buffer model plus
// a scoreboard of the words each sequence should present.
module tb_instr_buffer_reader;
  localparam int W  = 16;
  localparam int BS = 16;
  localparam int IW = $clog2(BS);
  localparam int LW = IW + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          skip_null;
  logic          flush;
  logic          busy;
  logic          done;
  logic [IW-1:0] start_index;
  logic [LW-1:0] length;
  logic [W-1:0]  mem [BS];

  int vectors     = 0;
  int miscompares = 0;

  instr_buffer_reader_if #(.Instr_word_size(W), .bs(BS)) bus ();

  instr_buffer_reader #(.Instr_word_size(W), .bs(BS)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .start_index (start_index),
    .length      (length),
    .skip_null   (skip_null),
    .flush       (flush),
    .busy        (busy),
    .done        (done),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  // Instruction buffer with a one-cycle registered read.
  always @(posedge clk) begin
    if (bus.rd_en) bus.rd_data <= mem[bus.rd_index];
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_reset_values();
    check_eq("rst_rd_index", 32'(bus.rd_index), 32'd0);
    check_eq("rst_rd_en", 32'(bus.rd_en), 32'd0);
    check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("rst_out_instr", 32'(bus.out_instr), 32'd0);
    check_eq("rst_out_index", 32'(bus.out_index), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
  endtask

  // abort: 0 = run to completion, 1 = flush after two pops, 2 = reset after two pops.
  // mode:  0 = out_ready always 1, 1 = random out_ready, 2 = stall cycles 3..7.
  task automatic run_seq(input int s_idx, input int len, input bit skip,
                         input int mode, input bit restart, input int abort);
    int exp_w[$];
    int exp_i[$];
    int exp_p[$];
    int nrd, ndone, npop, abort_step;
    bit prev_stall, finished, seen_done, ready;
    logic [W-1:0]  prev_instr;
    logic [IW-1:0] prev_index;
    nrd = 0; ndone = 0; npop = 0; abort_step = 0;
    prev_stall = 1'b0; finished = 1'b0; seen_done = 1'b0;
    prev_instr = '0; prev_index = '0;
    for (int i = 0; i < len; i++) begin
      int idx;
      idx = (s_idx + i) % BS;
      if (!(skip && mem[idx] == 16'h0000)) begin
        exp_w.push_back(int'(mem[idx]));
        exp_i.push_back(idx);
        exp_p.push_back(i);
      end
    end
    @(negedge clk);
    start = 1'b1;
    start_index = IW'(s_idx);
    length = LW'(len);
    skip_null = skip;
    flush = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    check_eq("start_cycle_rd_en", 32'(bus.rd_en), 32'd0);
    check_eq("start_cycle_valid", 32'(bus.out_valid), 32'd0);
    for (int cyc = 1; cyc <= 300 && !finished; cyc++) begin
      @(negedge clk);
      start = restart && (cyc == 1);
      if (cyc == 1) begin
        start_index = IW'(s_idx ^ 5);
        length = LW'(1);
      end
      flush = 1'b0;
      case (mode)
        0:       ready = 1'b1;
        1:       ready = ($urandom_range(0, 3) != 0);
        default: ready = !(cyc >= 3 && cyc < 8);
      endcase
      bus.out_ready = ready;
      if (abort_step == 1) begin
        bus.out_ready = 1'b0;
        if (abort == 1) begin
          flush = 1'b1;
          #1;
          abort_step = 2;
          continue;
        end
        rst = 1'b0;
        #1;
        check_reset_values();
        @(negedge clk);
        rst = 1'b1;
        finished = 1'b1;
        continue;
      end
      #1;
      if (abort_step == 2) begin
        check_eq("flush_valid", 32'(bus.out_valid), 32'd0);
        check_eq("flush_busy", 32'(busy), 32'd0);
        check_eq("flush_done", 32'(done), 32'd0);
        repeat (8) begin
          @(negedge clk);
          bus.out_ready = 1'b1;
          #1;
          check_eq("post_flush_done", 32'(done), 32'd0);
          check_eq("post_flush_rd_en", 32'(bus.rd_en), 32'd0);
          check_eq("post_flush_valid", 32'(bus.out_valid), 32'd0);
        end
        finished = 1'b1;
        continue;
      end
      if (seen_done) begin
        check_eq("end_busy", 32'(busy), 32'd0);
        check_eq("end_valid", 32'(bus.out_valid), 32'd0);
        finished = 1'b1;
        continue;
      end
      check_eq("busy", 32'(busy), 32'd1);
      if (bus.rd_en) begin
        check_eq("rd_index", 32'(bus.rd_index), 32'((s_idx + nrd) % BS));
        nrd++;
      end
      if (mode == 2 && cyc >= 3 && cyc < 8) begin
        check_eq("bp_rd_en", 32'(bus.rd_en), 32'd0);
      end
      if (prev_stall) begin
        check_eq("stall_valid", 32'(bus.out_valid), 32'd1);
        check_eq("stall_instr", 32'(bus.out_instr), 32'(prev_instr));
        check_eq("stall_index", 32'(bus.out_index), 32'(prev_index));
      end
      if (bus.out_valid && ready) begin
        if (exp_w.size() == 0) begin
          check_eq("extra_out", 32'(bus.out_valid), 32'd0);
        end else begin
          check_eq("out_instr", 32'(bus.out_instr), 32'(exp_w.pop_front()));
          check_eq("out_index", 32'(bus.out_index), 32'(exp_i.pop_front()));
          if (mode == 0) check_eq("out_cycle", 32'(cyc), 32'(3 + exp_p[0]));
          void'(exp_p.pop_front());
          npop++;
        end
      end
      if (done) begin
        ndone++;
        seen_done = 1'b1;
        if (mode == 0) check_eq("done_cycle", 32'(cyc), 32'((len == 0) ? 1 : len + 3));
      end
      prev_stall = bus.out_valid && !ready;
      prev_instr = bus.out_instr;
      prev_index = bus.out_index;
      if (abort != 0 && abort_step == 0 && npop == 2) abort_step = 1;
    end
    start = 1'b0;
    flush = 1'b0;
    if (abort == 0) begin
      check_eq("done_count", 32'(ndone), 32'd1);
      check_eq("reads_issued", 32'(nrd), 32'(len));
      check_eq("words_left", 32'(exp_w.size()), 32'd0);
    end else begin
      check_eq("abort_reached", 32'(finished), 32'd1);
      check_eq("abort_no_done", 32'(ndone), 32'd0);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic fill_random(input bit allow_null);
    for (int i = 0; i < BS; i++) begin
      if (allow_null && $urandom_range(0, 3) == 0) mem[i] = 16'h0000;
      else mem[i] = 16'($urandom_range(1, 65535));
    end
  endtask

  initial begin
    rst = 1'b0;
    start = 1'b0;
    skip_null = 1'b0;
    flush = 1'b0;
    start_index = '0;
    length = '0;
    bus.out_ready = 1'b0;
    fill_random(1'b0);
    #12;
    check_reset_values();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    mem[0] = 16'h1111; mem[1] = 16'h2222; mem[2] = 16'h3333; mem[3] = 16'h4444;
    run_seq(0, 4, 1'b0, 0, 1'b0, 0);

    run_seq(14, 4, 1'b0, 0, 1'b0, 0);

    mem[5] = 16'hA5A5; mem[6] = 16'h0000; mem[7] = 16'h5A5A;
    run_seq(5, 3, 1'b1, 0, 1'b0, 0);
    run_seq(5, 3, 1'b0, 0, 1'b0, 0);

    fill_random(1'b0);
    run_seq(8, 6, 1'b0, 2, 1'b0, 0);

    run_seq(3, 0, 1'b0, 0, 1'b1, 0);
    run_seq(9, 5, 1'b0, 0, 1'b1, 0);

    run_seq(0, 8, 1'b0, 0, 1'b0, 1);
    run_seq(0, 8, 1'b0, 0, 1'b0, 2);
    run_seq(2, 16, 1'b0, 0, 1'b0, 0);

    for (int r = 0; r < 40; r++) begin
      fill_random(1'b1);
      run_seq(int'($urandom_range(0, BS - 1)), int'($urandom_range(0, BS)),
              1'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
